rvtu_tag_ctrl: RTL and testbench

RVTU_TAG_CTRL -- requirements
Module: rvtu_tag_ctrl

---
 rtl/rvtu_tag_ctrl.sv | 116 +++++++++++
 tb/tb_rvtu_tag_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvtu_tag_ctrl.sv
// rvtu_tag_ctrl: controller for a 128-entry direct-mapped tag array.
// Does an invalidate sweep (after reset or on flush), lookups with a
// one-cycle SRAM read latency, and single-cycle fills.
//
// Request handshake: a request transfers in any cycle where req_valid
// and req_ready are both high. req_ready is high only in IDLE with no
// flush_start, and does not depend on req_valid. Responses carry no
// back-pressure: resp_valid is a single-cycle strobe.
module rvtu_tag_ctrl #(
  parameter int INIT_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [6:0]  resp_index,
  input  logic        flush_start,
  output logic        flush_busy,
  output logic [6:0]  sram_addr,
  output logic [21:0] sram_wdata,
  output logic        sram_wen,
  input  logic [21:0] sram_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    SWEEP  = 2'd0,
    IDLE   = 2'd1,
    LOOKUP = 2'd2
  } state_t;

  state_t      r_state;
  logic [6:0]  r_cnt;
  logic [20:0] r_tag;
  logic [6:0]  r_idx;

  state_t      w_state_nxt;
  logic [6:0]  w_cnt_nxt;
  logic        w_lookup_acc;

  assign dbg_state = r_state;

  // State, sweep counter and captured lookup tag/index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= (INIT_ON_RESET != 0) ? SWEEP : IDLE;
      r_cnt   <= 7'd0;
      r_tag   <= 21'd0;
      r_idx   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_lookup_acc) begin
        r_tag <= req_addr[31:11];
        r_idx <= req_addr[10:4];
      end
    end
  end

  // Next state and all outputs; anything with side effects is gated by
  // rst_n so nothing is written or reported while reset is held.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lookup_acc = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    resp_index   = 7'd0;
    flush_busy   = 1'b0;
    sram_addr    = 7'd0;
    sram_wdata   = 22'd0;
    sram_wen     = 1'b0;
    case (r_state)
      SWEEP: begin
        flush_busy = 1'b1;
        sram_wen   = rst_n;
        sram_addr  = r_cnt;
        w_cnt_nxt  = r_cnt + 7'd1;
        if (r_cnt == 7'd127) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (flush_start) begin
          // Flush takes priority; a same-cycle request is not accepted.
          w_cnt_nxt   = 7'd0;
          w_state_nxt = SWEEP;
        end else begin
          req_ready = rst_n;
          if (req_valid && rst_n) begin
            sram_addr = req_addr[10:4];
            if (req_op) begin
              sram_wdata = {1'b1, req_addr[31:11]};
              sram_wen   = 1'b1;
            end else begin
              w_lookup_acc = 1'b1;
              w_state_nxt  = LOOKUP;
            end
          end
        end
      end
      LOOKUP: begin
        // SRAM read data for the address presented last cycle is here now.
        resp_valid  = rst_n;
        resp_index  = rst_n ? r_idx : 7'd0;
        resp_hit    = rst_n && sram_rdata[21] && (sram_rdata[20:0] == r_tag);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rvtu_tag_ctrl.sv
// Bench for rvtu_tag_ctrl: behavioural one-cycle-latency tag SRAM,
// table of lookups/fills, and hand-written multi-cycle sequences for
// sweeps, flush collisions, back-to-back lookups and reset aborts.
module tb_rvtu_tag_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_hit;
  logic [6:0]  resp_index;
  logic        flush_start;
  logic        flush_busy;
  logic [6:0]  sram_addr;
  logic [21:0] sram_wdata;
  logic        sram_wen;
  logic [21:0] sram_rdata;
  logic [1:0]  dbg_state;

  rvtu_tag_ctrl #(.INIT_ON_RESET(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_index  (resp_index),
    .flush_start (flush_start),
    .flush_busy  (flush_busy),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_wen    (sram_wen),
    .sram_rdata  (sram_rdata),
    .dbg_state   (dbg_state)
  );

  // Tag SRAM model: synchronous write, registered read.
  logic [21:0] mem [0:127];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  logic       prev_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every resp_valid must match the oldest expected lookup.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      chk("no_consec_resp", 32'(prev_rv), 32'd0);
      if (exp_q.size() == 0) begin
        chk("resp_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp", {24'd0, resp_hit, resp_index}, {24'd0, mon_e});
      end
    end
    prev_rv = (resp_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and hold it until accepted (bounded).
  task automatic do_req(input logic op, input logic [31:0] addr, input logic exp_hit);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        if (op) begin
          chk("fill_write", {9'd0, sram_wen, sram_wdata}, {9'd0, 1'b1, 1'b1, addr[31:11]});
          chk("fill_addr", 32'(sram_addr), 32'(addr[10:4]));
        end else begin
          chk("lookup_addr", {24'd0, sram_wen, sram_addr}, {24'd0, 1'b0, addr[10:4]});
          exp_q.push_back({exp_hit, addr[10:4]});
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("req_accepted", 32'(ok), 32'd1);
  endtask

  // Called in the first sweep cycle; checks every write and the length.
  // Returns at the negedge of the first cycle after the sweep.
  task automatic check_sweep(input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (flush_busy !== 1'b1) begin
        done = 1'b1;
      end else begin
        chk(name, {2'd0, sram_wen, sram_wdata, sram_addr}, {2'd0, 1'b1, 22'd0, 7'(n)});
        n++;
        @(posedge clk);
        #1;
      end
    end
    chk({name, "_len"}, 32'(n), 32'd128);
    chk({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic        hit;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit found;

    vecs[0]  = '{1'b0, 32'h0000_0010, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'h1234_5670, 1'b0};
    vecs[3]  = '{1'b0, 32'h1234_5678, 1'b1};
    vecs[4]  = '{1'b1, 32'h0D5E_6850, 1'b0};
    vecs[5]  = '{1'b0, 32'h0D5E_7050, 1'b0};
    vecs[6]  = '{1'b0, 32'h0D5E_685C, 1'b1};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF0, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_07F0, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_000C, 1'b1};

    // Garbage that would hit tag 0 everywhere unless the sweep clears it.
    for (int i = 0; i < 128; i++) mem[i] = {1'b1, 21'd0};

    // Reset with a request pending: nothing may be written or accepted.
    rst_n       = 1'b0;
    req_valid   = 1'b1;
    req_op      = 1'b1;
    req_addr    = 32'h0000_0010;
    flush_start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_wen", 32'(sram_wen), 32'd0);
    chk("reset_resp", {23'd0, resp_valid, resp_hit, resp_index}, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 1'b0;

    check_sweep("init_sweep");
    tick();

    // Table of fills and lookups.
    for (int i = 0; i < 12; i++) do_req(vecs[i].op, vecs[i].addr, vecs[i].hit);
    tick();
    tick();

    // flush_start during LOOKUP is ignored and not queued.
    do_req(1'b0, 32'h1234_5678, 1'b1);
    flush_start = 1'b1;
    @(negedge clk);
    chk("lookup_ready", 32'(req_ready), 32'd0);
    chk("lookup_flush_busy", 32'(flush_busy), 32'd0);
    tick();
    flush_start = 1'b0;
    @(negedge clk);
    chk("ignored_flush_busy", 32'(flush_busy), 32'd0);
    chk("ignored_flush_ready", 32'(req_ready), 32'd1);
    tick();

    // Flush and lookup in the same cycle: flush wins, lookup waits.
    flush_start = 1'b1;
    req_valid   = 1'b1;
    req_op      = 1'b0;
    req_addr    = 32'h1234_5678;
    @(negedge clk);
    chk("collide_ready", 32'(req_ready), 32'd0);
    chk("collide_wen", 32'(sram_wen), 32'd0);
    tick();
    flush_start = 1'b0;
    check_sweep("flush_sweep");
    chk("collide_lookup_addr", {24'd0, sram_wen, sram_addr}, {24'd0, 1'b0, 7'h67});
    if (req_ready === 1'b1) exp_q.push_back({1'b0, 7'h67});
    tick();
    req_valid = 1'b0;
    tick();
    do_req(1'b0, 32'h0D5E_685C, 1'b0);
    tick();

    // Back-to-back lookups held valid: accepted every other cycle.
    do_req(1'b1, 32'h0000_1230, 1'b0);
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_addr  = 32'h0000_1234;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(req_ready), 32'((k % 2) == 0));
      if (req_ready === 1'b1) begin
        exp_q.push_back({1'b1, 7'h23});
        acc++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd5);
    tick();
    tick();

    // Reset in the middle of a sweep restarts it from index 0.
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (flush_busy === 1'b1 && sram_addr == 7'd40) begin
        found = 1'b1;
        rst_n = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("mid_sweep_reached_40", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_reset_wen", 32'(sram_wen), 32'd0);
    chk("mid_reset_busy", 32'(flush_busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_sweep("restart_sweep");
    tick();
    do_req(1'b0, 32'h0000_1234, 1'b0);
    tick();

    // Reset during LOOKUP: the lookup produces no response.
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_addr  = 32'h0000_1234;
    @(negedge clk);
    chk("abort_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    check_sweep("post_abort_sweep");
    tick();
    tick();

    // ---------------- final report ----------------
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
